rolling_average_window: RTL and testbench

Multi-channel rolling-average engine, the parametrised successor of the fixed 8-deep, 5-bit, single-channel averager. Samples arrive on a slow asynchronous strobe tagged with a channel number. Each channel keeps its own circular history and running sum. The window is selectable at run time as a power of two up to MAX_DEPTH, and each result comes out with a valid pulse, a window-filled flag and an overrun flag.

---
 rtl/rolling_average_window_pkg.sv | 19 +
 rtl/rolling_average_window_strobe_sync.sv | 23 ++
 rtl/rolling_average_window.sv | 155 +++++++++++++++
 tb/tb_rolling_average_window.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rolling_average_window_pkg.sv
// ra_pkg: shared FSM type, width helpers and window clamp for rolling_average_window
package ra_pkg;
    typedef enum logic [1:0] {IDLE, READ, UPDATE, OUT} state_e;
    function automatic int sum_bits(input int bits, input int depth_log2);
        return bits + depth_log2;
    endfunction
    function automatic int ch_bits(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction
    function automatic int win_bits(input int depth_log2);
        return (depth_log2 > 0) ? $clog2(depth_log2 + 1) : 1;
    endfunction
    function automatic int max_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction
    function automatic int clamp_win(input int k, input int depth_log2);
        return (k > depth_log2) ? depth_log2 : k;
    endfunction
endpackage

// File: rtl/rolling_average_window_strobe_sync.sv
// strobe_sync: 2-FF synchroniser on an asynchronous strobe with a registered rising-edge pulse
module strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_strobe,
    output logic o_pulse
);
    logic s1_q, s2_q, s3_q, pulse_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= i_strobe;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= s2_q & ~s3_q;
        end
    end
    assign o_pulse = pulse_q;
endmodule

// File: rtl/rolling_average_window.sv
// rolling_average_window: multi-channel power-of-two rolling average with per-channel
// circular history, running sum and saturating fill count.
module rolling_average_window
    import ra_pkg::*;
#(
    parameter int BITS_PER_ELEM  = 5,
    parameter int MAX_DEPTH_LOG2 = 3,
    parameter int NUM_CH         = 2,
    localparam int CH_BITS       = ch_bits(NUM_CH),
    localparam int WIN_BITS      = win_bits(MAX_DEPTH_LOG2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_data_clk,
    input  logic [BITS_PER_ELEM-1:0] i_value,
    input  logic [CH_BITS-1:0]       i_ch,
    input  logic [WIN_BITS-1:0]      i_win_log2,
    input  logic                     i_flush,
    output logic [BITS_PER_ELEM-1:0] o_ra,
    output logic [CH_BITS-1:0]       o_ra_ch,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_overrun
);
    localparam int SUM_BITS  = sum_bits(BITS_PER_ELEM, MAX_DEPTH_LOG2);
    localparam int MAX_DEPTH = max_depth(MAX_DEPTH_LOG2);
    localparam int AB        = CH_BITS + MAX_DEPTH_LOG2;

    typedef logic [BITS_PER_ELEM-1:0]  elem_t;
    typedef logic [SUM_BITS-1:0]       sum_t;
    typedef logic [MAX_DEPTH_LOG2:0]   cnt_t;
    typedef logic [MAX_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [AB-1:0]             addr_t;

    state_e              state_q, state_d;
    logic [WIN_BITS-1:0] win_q, win_d, win_in;
    sum_t                sum_q [NUM_CH];
    sum_t                sum_d [NUM_CH];
    cnt_t                cnt_q [NUM_CH];
    cnt_t                cnt_d [NUM_CH];
    ptr_t                wptr_q [NUM_CH];
    ptr_t                wptr_d [NUM_CH];
    elem_t               val_q, val_d, old_q;
    logic [CH_BITS-1:0]  ch_q, ch_d, ra_ch_q, ra_ch_d;
    addr_t               addr_q, addr_d, wr_addr;
    elem_t               ra_q, ra_d;
    logic                full_q, full_d, ovr_q, ovr_d;
    elem_t               mem [NUM_CH*MAX_DEPTH];
    logic                accept, flush, full_old;
    cnt_t                win_len, next_cnt;
    sum_t                next_sum;

    strobe_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_strobe (i_data_clk),
        .o_pulse  (accept)
    );

    assign win_in   = WIN_BITS'(clamp_win(int'(i_win_log2), MAX_DEPTH_LOG2));
    assign win_len  = cnt_t'(1) << win_q;
    assign full_old = cnt_q[ch_q] == win_len;
    // Stored history only contributes once the window is full; cnt gates stale RAM data.
    assign next_sum = sum_q[ch_q] + sum_t'(val_q) - (full_old ? sum_t'(old_q) : sum_t'(0));
    assign next_cnt = full_old ? win_len : cnt_q[ch_q] + cnt_t'(1);
    assign wr_addr  = {ch_q, wptr_q[ch_q]};
    assign flush    = (state_q == IDLE) && (i_flush || win_in != win_q);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        val_d   = val_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        ra_d    = ra_q;
        ra_ch_d = ra_ch_q;
        full_d  = full_q;
        ovr_d   = ovr_q;
        if (flush) begin
            win_d  = win_in;
            sum_d  = '{default: '0};
            cnt_d  = '{default: '0};
            wptr_d = '{default: '0};
            ovr_d  = 1'b0;
            full_d = 1'b0;
        end else if (accept) begin
            if (state_q != IDLE || int'(i_ch) >= NUM_CH) begin
                ovr_d = 1'b1;
            end else begin
                val_d   = i_value;
                ch_d    = i_ch;
                addr_d  = {i_ch, ptr_t'(wptr_q[i_ch] - ptr_t'(win_len))};
                state_d = READ;
            end
        end
        case (state_q)
            READ:   state_d = UPDATE;
            UPDATE: begin
                sum_d[ch_q]  = next_sum;
                cnt_d[ch_q]  = next_cnt;
                wptr_d[ch_q] = wptr_q[ch_q] + ptr_t'(1);
                ra_d         = elem_t'(next_sum >> win_q);
                ra_ch_d      = ch_q;
                full_d       = next_cnt == win_len;
                state_d      = OUT;
            end
            OUT:    state_d = IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= WIN_BITS'(MAX_DEPTH_LOG2);
            sum_q   <= '{default: '0};
            cnt_q   <= '{default: '0};
            wptr_q  <= '{default: '0};
            val_q   <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            ra_q    <= '0;
            ra_ch_q <= '0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            val_q   <= val_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            ra_q    <= ra_d;
            ra_ch_q <= ra_ch_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == UPDATE) mem[wr_addr] <= val_q;
        if (state_q == READ) old_q <= mem[addr_q];
    end

    assign o_ra      = ra_q;
    assign o_ra_ch   = ra_ch_q;
    assign o_valid   = state_q == OUT;
    assign o_full    = full_q;
    assign o_overrun = ovr_q;
endmodule

// File: tb/tb_rolling_average_window.sv
// tb_rolling_average_window: directed self-checking bench for rolling_average_window
module tb_rolling_average_window;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_data_clk = 1'b0;
    logic [4:0] i_value = '0;
    logic [0:0] i_ch = '0;
    logic [1:0] i_win_log2 = 2'd3;
    logic       i_flush = 1'b0;
    logic [4:0] o_ra;
    logic [0:0] o_ra_ch;
    logic       o_valid, o_full, o_overrun;
    int total = 0;
    int bad = 0;
    int nv;

    rolling_average_window dut (
        .clk        (clk),
        .rst        (rst),
        .i_data_clk (i_data_clk),
        .i_value    (i_value),
        .i_ch       (i_ch),
        .i_win_log2 (i_win_log2),
        .i_flush    (i_flush),
        .o_ra       (o_ra),
        .o_ra_ch    (o_ra_ch),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edge 0 is the first posedge seeing the strobe high; result must appear at edge 5 only.
    task automatic sample(input logic [4:0] v, input logic ch, input logic [4:0] exp_ra,
                          input logic exp_full, input string tag);
        @(negedge clk);
        i_value = v;
        i_ch = ch;
        i_data_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_data_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk(o_valid, 0, {tag, "_early"});
        @(posedge clk);
        #1 chk(o_valid, 1, {tag, "_valid"});
        chk(o_ra, exp_ra, {tag, "_ra"});
        chk(o_ra_ch, ch, {tag, "_ch"});
        chk(o_full, exp_full, {tag, "_full"});
        @(posedge clk);
        #1 chk(o_valid, 0, {tag, "_vfall"});
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk(o_ra, 0, "rst_ra");
        chk(o_ra_ch, 0, "rst_ch");
        chk(o_valid, 0, "rst_valid");
        chk(o_full, 0, "rst_full");
        chk(o_overrun, 0, "rst_ovr");
        rst = 1'b0;

        sample(5'd20, 1'b0, 5'd2, 1'b0, "first");
        pulse_flush();

        for (int i = 1; i <= 8; i++)
            sample(5'd31, 1'b0, 5'((31 * i) >> 3), i == 8, $sformatf("fill%0d", i));
        sample(5'd0, 1'b0, 5'd27, 1'b1, "slide");

        @(negedge clk);
        i_win_log2 = 2'd1;
        sample(5'd10, 1'b0, 5'd5, 1'b0, "k1_c0a");
        sample(5'd30, 1'b1, 5'd15, 1'b0, "k1_c1a");
        sample(5'd10, 1'b0, 5'd10, 1'b1, "k1_c0b");
        sample(5'd30, 1'b1, 5'd30, 1'b1, "k1_c1b");

        @(negedge clk);
        i_win_log2 = 2'd3;
        for (int i = 1; i <= 8; i++)
            sample(5'd8, 1'b0, 5'(i), i == 8, $sformatf("k3_%0d", i));
        @(negedge clk);
        i_win_log2 = 2'd2;
        for (int i = 1; i <= 4; i++)
            sample(5'd8, 1'b0, 5'(2 * i), i == 4, $sformatf("k2_%0d", i));
        @(negedge clk);
        i_win_log2 = 2'd3;
        sample(5'd8, 1'b0, 5'd1, 1'b0, "k3_again");

        // Second rising edge lands while the first sample is still in flight.
        @(negedge clk);
        i_value = 5'd4;
        i_ch = 1'b0;
        i_data_clk = 1'b1;
        @(posedge clk);
        #1 i_data_clk = 1'b0;
        @(posedge clk);
        #1 i_data_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_data_clk = 1'b0;
        nv = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (o_valid) nv++;
        end
        chk(nv, 1, "ovr_nvalid");
        chk(o_ra, 1, "ovr_ra");
        chk(o_overrun, 1, "ovr_set");
        sample(5'd4, 1'b0, 5'd2, 1'b0, "ovr_sum");
        chk(o_overrun, 1, "ovr_sticky");
        pulse_flush();
        chk(o_overrun, 0, "flush_ovr");
        chk(o_full, 0, "flush_full");
        chk(o_ra, 2, "flush_ra_hold");

        @(negedge clk);
        i_flush = 1'b1;
        i_value = 5'd9;
        i_data_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_data_clk = 1'b0;
        nv = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (o_valid) nv++;
        end
        chk(nv, 0, "flushwin_nvalid");
        chk(o_overrun, 0, "flushwin_ovr");
        @(negedge clk);
        i_flush = 1'b0;

        @(negedge clk);
        i_value = 5'd1;
        i_data_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_data_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk(o_ra, 0, "midrst_ra");
        chk(o_valid, 0, "midrst_valid");
        chk(o_full, 0, "midrst_full");
        repeat (2) @(negedge clk);
        i_win_log2 = 2'd0;
        rst = 1'b0;
        sample(5'd16, 1'b0, 5'd16, 1'b1, "k0_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
